// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampling UART receiver with ready/valid hold, parity/frame flags and overrun pulse
// Ports: sys_clk, rst_n (async, active-low); serial_data_in (async line, idle high); rx_ready (consumer accept);
//        rx_data/rx_valid/parity_err/frame_err held until handshake; overrun one-cycle drop pulse; busy (not IDLE).
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority voting of samples at ticks 6/7/8.
module uart_rx_core #(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int CLK_DIV     = 27
) (
   input  logic                 sys_clk,
   input  logic                 rst_n,
   input  logic                 serial_data_in,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_BITS);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state, state_nx;
   logic [1:0] sync_ff, warm;
   logic rx_s, rx_q, start_edge, tick, smp, bit_end, bit_val, done, load, pe_calc, par_bit;
   logic [DW-1:0] div_cnt;
   logic [3:0] tick_cnt;
   logic [BW-1:0] bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   assign rx_s = sync_ff[1];
   // rx_q only reports a genuine high once the synchroniser holds real line data, so a line
   // that is already low when reset releases never looks like a start edge
   assign start_edge = state == IDLE && rx_q && !rx_s;
   assign tick = div_cnt == DW'(CLK_DIV - 1);
   assign bit_end = tick && tick_cnt == 4'd15;
   assign pe_calc = PARITY_MODE == 0 ? 1'b0 : (^shreg) ^ par_bit ^ (PARITY_MODE == 2);
`ifdef UART_RX_MAJORITY_EN
   logic s6, s7;
   assign smp = tick && tick_cnt == 4'd8;
   assign bit_val = (s6 & s7) | (s6 & rx_s) | (s7 & rx_s);
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         s6 <= 1'b1;
         s7 <= 1'b1;
      end else if (tick && tick_cnt == 4'd6) s6 <= rx_s;
      else if (tick && tick_cnt == 4'd7) s7 <= rx_s;
`else
   assign smp = tick && tick_cnt == 4'd7;
   assign bit_val = rx_s;
`endif
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         sync_ff <= 2'b11;
         warm <= 2'b00;
         rx_q <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[0], serial_data_in};
         warm <= {warm[0], 1'b1};
         rx_q <= warm[1] & rx_s;
      end
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         div_cnt <= '0;
         tick_cnt <= '0;
      end else if (start_edge) begin
         div_cnt <= '0;
         tick_cnt <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick && state != IDLE) tick_cnt <= tick_cnt + 1'b1;
      end
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         bit_cnt <= '0;
         shreg <= '0;
         par_bit <= 1'b0;
      end else begin
         if (state == START) bit_cnt <= '0;
         else if (state == DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
         if (state == DATA && smp) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
         if (state == PARITY && smp) par_bit <= bit_val;
      end
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_edge) state_nx = START;
         START:   if (smp && bit_val) state_nx = IDLE;
                  else if (bit_end) state_nx = DATA;
         DATA:    if (bit_end && bit_cnt == BW'(DATA_BITS - 1)) state_nx = PARITY_MODE == 0 ? STOP : PARITY;
         PARITY:  if (bit_end) state_nx = STOP;
         STOP:    if (smp) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // stop bit is judged at its midpoint so the next start edge can be caught without a gap
   always_comb begin
      busy = state != IDLE;
      done = state == STOP && smp;
      load = done && (!rx_valid || rx_ready);
   end
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         rx_data <= '0;
         rx_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= done && rx_valid && !rx_ready;
         if (load) begin
            rx_data <= shreg;
            parity_err <= pe_calc;
            frame_err <= !bit_val;
            rx_valid <= 1'b1;
         end else if (rx_ready) rx_valid <= 1'b0;
      end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core (8 data bits, even parity, 4 clocks per tick)
module tb_uart_rx_core;
   logic sys_clk = 1'b0, rst_n = 1'b0, serial_data_in = 1'b1, rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic rx_valid, parity_err, frame_err, overrun, busy;
   int tests = 0, fails = 0, ovr_cnt = 0;
   logic [9:0] cap_q[$];
   typedef struct {
      logic [7:0] d;
      logic pb;
      logic sb;
      int glitch;
      logic [7:0] ed;
      logic epe;
      logic efe;
   } vec_t;
   vec_t vecs[4];
   uart_rx_core #(.DATA_BITS(8), .PARITY_MODE(1), .CLK_DIV(4)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .serial_data_in(serial_data_in), .rx_ready(rx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );
   always #5 sys_clk = ~sys_clk;
   always @(negedge sys_clk) begin
      if (rx_valid && rx_ready) cap_q.push_back({rx_data, parity_err, frame_err});
      if (overrun) ovr_cnt++;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask
   // one bit = 64 clocks; index i of the frame is held for exactly one clock
   task automatic send(input logic [7:0] d, input logic pb, input logic sb, input int glitch, input int rst_at, input int len);
      logic [10:0] bits;
      bits = {sb, pb, d, 1'b0};
      for (int i = 0; i < len; i++) begin
         serial_data_in = bits[i / 64] & (i != glitch);
         rst_n = !(i >= rst_at && i < rst_at + 3);
         step(1);
      end
      serial_data_in = 1'b1;
   endtask
   task automatic chk_frame(input string name, input logic [7:0] ed, input logic epe, input logic efe);
      logic [9:0] c;
      chk({name, " count"}, 32'(cap_q.size()), 32'd1);
      c = cap_q.size() != 0 ? cap_q.pop_front() : 10'bx;
      chk({name, " data"}, 32'(c[9:2]), 32'(ed));
      chk({name, " parity_err"}, 32'(c[1]), 32'(epe));
      chk({name, " frame_err"}, 32'(c[0]), 32'(efe));
      cap_q.delete();
   endtask
   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b1, -1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 1'b1, -1, 8'h3C, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 1'b0, 1'b0, -1, 8'h00, 1'b0, 1'b1};
`ifdef UART_RX_MAJORITY_EN
      vecs[3] = '{8'hFF, 1'b0, 1'b1, 224, 8'hFF, 1'b0, 1'b0};
`else
      vecs[3] = '{8'hFF, 1'b0, 1'b1, 224, 8'hFB, 1'b1, 1'b0};
`endif
      step(3);
      chk("rst rx_valid", 32'(rx_valid), 32'd0);
      chk("rst rx_data", 32'(rx_data), 32'd0);
      chk("rst parity_err", 32'(parity_err), 32'd0);
      chk("rst frame_err", 32'(frame_err), 32'd0);
      chk("rst overrun", 32'(overrun), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      step(10);
      for (int i = 0; i < 4; i++) begin
         send(vecs[i].d, vecs[i].pb, vecs[i].sb, vecs[i].glitch, -10, 704);
         step(20);
         chk_frame($sformatf("vec%0d", i), vecs[i].ed, vecs[i].epe, vecs[i].efe);
      end
      chk("no overrun yet", 32'(ovr_cnt), 32'd0);
      serial_data_in = 1'b0;
      step(10);
      chk("false start busy", 32'(busy), 32'd1);
      step(10);
      serial_data_in = 1'b1;
      step(60);
      chk("false start idle", 32'(busy), 32'd0);
      chk("false start no frame", 32'(cap_q.size()), 32'd0);
      rx_ready = 1'b0;
      send(8'h11, 1'b0, 1'b1, -1, -10, 704);
      send(8'h22, 1'b0, 1'b1, -1, -10, 704);
      step(20);
      chk("ovr rx_valid", 32'(rx_valid), 32'd1);
      chk("ovr rx_data", 32'(rx_data), 32'h11);
      chk("ovr pulse cycles", 32'(ovr_cnt), 32'd1);
      chk("ovr no handshake", 32'(cap_q.size()), 32'd0);
      rx_ready = 1'b1;
      step(1);
      chk("ovr cleared", 32'(rx_valid), 32'd0);
      chk_frame("ovr held", 8'h11, 1'b0, 1'b0);
      send(8'h55, 1'b0, 1'b1, -1, 270, 320);
      step(800);
      chk("rst mid busy", 32'(busy), 32'd0);
      chk("rst mid no frame", 32'(cap_q.size()), 32'd0);
      send(8'h96, 1'b0, 1'b1, -1, -10, 704);
      step(20);
      chk_frame("after rst", 8'h96, 1'b0, 1'b0);
      chk("final overrun count", 32'(ovr_cnt), 32'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
- REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
- REQ-002 SHALL have parameter PARITY_MODE, default 0: 0 none, 1 even, 2 odd.
- REQ-003 SHALL have parameter CLK_DIV, default 27: sys_clk cycles per oversample tick (legal >=2); bit time = 16*CLK_DIV cycles.
- REQ-004 SHALL have port sys_clk  input  1  single clock; all logic on rising edge.
- REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
- REQ-006 SHALL have port serial_data_in  input  1  asynchronous line, idle high.
- REQ-007 SHALL have port rx_ready  input  1  consumer accepts rx_data this cycle.
- REQ-008 SHALL have port rx_data  output  DATA_BITS  received word, LSB = first bit on line.
- REQ-009 SHALL have port rx_valid  output  1  rx_data and error flags valid.
- REQ-010 SHALL have port parity_err  output  1  parity mismatch for held word (0 when PARITY_MODE=0).
- REQ-011 SHALL have port frame_err  output  1  stop bit sampled low for held word.
- REQ-012 SHALL have port overrun  output  1  one-cycle pulse: completed frame dropped.
- REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
- REQ-014 SHALL pass serial_data_in through a 2-flop synchroniser (reset value 1); all sampling uses the synchronised line.
- REQ-015 SHALL generate a tick every CLK_DIV cycles from a free-running divider; a 4-bit tick counter SHALL count 0..15 per bit period.
- REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY_MODE=0.
- REQ-017 IDLE -> START on synchronised line low; divider and tick counter cleared on entry.
- REQ-018 START: at tick count 7, line high -> IDLE (false start, nothing reported); line low -> continue, DATA entered at tick count 15.
- REQ-019 DATA: sample at tick count 7 of each bit, shift in LSB first; after DATA_BITS bits -> PARITY or STOP.
- REQ-020 PARITY: sample at tick count 7; parity_err = XOR(data, sampled bit) for even, inverted for odd.
- REQ-021 STOP: sample at tick count 7; frame_err = NOT sample; frame completes that cycle and FSM returns to IDLE (half stop bit), permitting back-to-back frames.
- REQ-022 On completion with rx_valid=0, SHALL load rx_data, parity_err, frame_err and set rx_valid the following cycle.
- REQ-023 Frames with errors SHALL still be delivered, flags set.
- REQ-024 rx_valid SHALL stay high, rx_data and flags stable, until a cycle with rx_valid=1 and rx_ready=1; then rx_valid clears.
- REQ-025 Completion in the same cycle as an accepting handshake SHALL load the new frame, rx_valid stays 1, no overrun.
- REQ-026 Completion while rx_valid=1 and no handshake SHALL drop the new frame, hold old data, pulse overrun one cycle.

Reset
- REQ-027 rst_n low SHALL immediately force IDLE, counters 0, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, overrun 0, busy 0, synchroniser 1.
- REQ-028 Reset mid-frame SHALL discard the partial frame; after release, reception resumes only at the next high-to-low line transition seen in IDLE.

Configuration
- REQ-029 Macro UART_RX_MAJORITY_EN defined: each bit value (start, data, parity, stop) SHALL be the 2-of-3 majority of samples at tick counts 6, 7, 8, decided at tick 8.
- REQ-030 Macro undefined: single sample at tick count 7 as in REQ-018..021; no majority logic present.

Verification (DATA_BITS=8, PARITY_MODE=1, CLK_DIV=4, bit = 64 cycles, rx_ready=1 unless stated)
- REQ-031 Send 0xA5, parity 0, stop 1 -> rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0.
- REQ-032 Send 0x3C with parity bit 1 -> rx_data=0x3C, parity_err=1; send 0x00 with stop 0 -> frame_err=1.
- REQ-033 Line low for 20 cycles then high -> no rx_valid, busy returns 0 within one bit time.
- REQ-034 rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data=0x11 held, overrun one-cycle pulse at second completion; rx_ready=1 then clears rx_valid.
- REQ-035 rst_n low for 3 cycles in 4th data bit of 0x55, then send 0x96 -> only 0x96 delivered, no errors.
- REQ-036 UART_RX_MAJORITY_EN defined, 1-cycle low glitch at tick 7 of a 1 data bit in 0xFF -> rx_data=0xFF; undefined -> rx_data=0xFB (glitch in bit 2).
